// File: rtl/uart_rx_os.sv
// ============================================================================
// Module   : uart_rx_os
// Purpose  : Oversampling UART receiver with runtime baud divisor, 2-FF input
//            synchroniser, mid-bit sampling, false-start and framing checks.
//            Optional parity checking is enabled by defining UART_RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx_os #(
    parameter int DATA_BITS  = 8,
    parameter int OS_RATE    = 16,
    parameter int DIV_W      = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rxd,
    input  logic [DIV_W-1:0]     baud_div,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 ren,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int OS_W = $clog2(OS_RATE);
    localparam int BC_W = $clog2(DATA_BITS + 1);

    localparam logic [OS_W-1:0] OS_HALF  = OS_W'(OS_RATE / 2 - 1);
    localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OS_RATE - 1);
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_os: DATA_BITS must be 5..9");
    end
    if (OS_RATE < 4 || (OS_RATE % 2) != 0) begin : g_bad_os_rate
        $error("uart_rx_os: OS_RATE must be even and >= 4");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("uart_rx_os: PARITY_ODD must be 0 or 1");
    end

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4
    } state_t;
`endif

    state_t               state_q, state_d;
    logic                 sync1_q, sync2_q, prev_q;
    logic                 rxs;
    logic [DIV_W-1:0]     div_lat_q, div_lat_d;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
    logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rdata_q, rdata_d;
    logic                 ren_q, ren_d;
    logic                 frame_err_q, frame_err_d;
    logic                 tick;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 parity_err_q, parity_err_d;
`endif

    // Synchroniser and edge-detect history idle high so reset never looks like a start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rxs  = sync2_q;
    assign tick = (state_q != S_IDLE) && (div_cnt_q == div_lat_q);

    always_comb begin
        state_d     = state_q;
        div_lat_d   = div_lat_q;
        div_cnt_d   = div_cnt_q;
        os_cnt_d    = os_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rdata_d     = rdata_q;
        ren_d       = 1'b0;
        frame_err_d = frame_err_q;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = parity_err_q;
`endif

        if (state_q == S_IDLE || tick) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                div_lat_d = baud_div;
                if (prev_q && !rxs) begin
                    state_d   = S_START;
                    os_cnt_d  = '0;
                    bit_cnt_d = '0;
                end
            end

            S_START: begin
                if (tick) begin
                    if (os_cnt_q == OS_HALF) begin
                        os_cnt_d = '0;
                        state_d  = rxs ? S_IDLE : S_DATA;
                    end else begin
                        os_cnt_d = os_cnt_q + OS_W'(1);
                    end
                end
            end

            S_DATA: begin
                if (tick) begin
                    if (os_cnt_q == OS_LAST) begin
                        os_cnt_d  = '0;
                        // Shift in at the MSB so the first (LSB) bit lands in bit 0.
                        shift_d   = {rxs, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                        if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + OS_W'(1);
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    if (os_cnt_q == OS_LAST) begin
                        os_cnt_d  = '0;
                        par_bad_d = (^shift_q) ^ rxs ^ 1'(PARITY_ODD);
                        state_d   = S_STOP;
                    end else begin
                        os_cnt_d = os_cnt_q + OS_W'(1);
                    end
                end
            end
`endif

            S_STOP: begin
                if (tick) begin
                    if (os_cnt_q == OS_LAST) begin
                        os_cnt_d    = '0;
                        ren_d       = 1'b1;
                        rdata_d     = shift_q;
                        frame_err_d = ~rxs;
`ifdef UART_RX_PARITY_EN
                        parity_err_d = par_bad_q;
`endif
                        state_d     = S_IDLE;
                    end else begin
                        os_cnt_d = os_cnt_q + OS_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            div_lat_q   <= '0;
            div_cnt_q   <= '0;
            os_cnt_q    <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rdata_q     <= '0;
            ren_q       <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_lat_q   <= div_lat_d;
            div_cnt_q   <= div_cnt_d;
            os_cnt_q    <= os_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rdata_q     <= rdata_d;
            ren_q       <= ren_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rdata     = rdata_q;
    assign ren       = ren_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_os.sv
// ============================================================================
// Module   : tb_uart_rx_os
// Purpose  : Scoreboard testbench for uart_rx_os (define UART_RX_PARITY_EN to
//            also exercise parity).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_os;

    localparam int DATA_BITS  = 8;
    localparam int OS_RATE    = 16;
    localparam int DIV_W      = 16;
    localparam int PARITY_ODD = 0;

    typedef struct packed {
        logic [DATA_BITS-1:0] d;
        logic                 fe;
        logic                 pe;
    } rec_t;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 rxd = 1'b1;
    logic [DIV_W-1:0]     baud_div = 16'd3;
    logic [DATA_BITS-1:0] rdata;
    logic                 ren;
    logic                 frame_err;
    logic                 parity_err;
    logic                 busy;

    int   total = 0;
    int   bad = 0;
    int   ren_cnt = 0;
    int   bit_clks = 64;
    rec_t exp_q[$];
    rec_t got_q[$];

    uart_rx_os #(
        .DATA_BITS (DATA_BITS),
        .OS_RATE   (OS_RATE),
        .DIV_W     (DIV_W),
        .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rxd       (rxd),
        .baud_div  (baud_div),
        .rdata     (rdata),
        .ren       (ren),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Capture every strobe cycle; a stretched ren shows up as an extra entry.
    always @(negedge clk) begin
        if (ren === 1'b1) begin
            got_q.push_back({rdata, frame_err, parity_err});
            ren_cnt++;
        end
    end

    function automatic logic good_par(input logic [DATA_BITS-1:0] d);
        return (^d) ^ 1'(PARITY_ODD);
    endfunction

    task automatic hold(input logic v, input int n);
        rxd = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic stop,
                              input int stop_len, input logic par);
        rec_t e;
        e.d  = d;
        e.fe = ~stop;
        e.pe = 1'b0;
`ifdef UART_RX_PARITY_EN
        e.pe = (^d) ^ par ^ 1'(PARITY_ODD);
`endif
        exp_q.push_back(e);
        hold(1'b0, bit_clks);
        for (int i = 0; i < DATA_BITS; i++) hold(d[i], bit_clks);
`ifdef UART_RX_PARITY_EN
        hold(par, bit_clks);
`endif
        hold(stop, stop_len);
    endtask

    task automatic wait_got(input int n, output bit timed_out);
        int k = 0;
        while (got_q.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        timed_out = (got_q.size() < n);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (ren !== 1'b0)       begin bad++; $display("FAIL reset_ren: got %b want 0", ren); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (rdata !== '0)       begin bad++; $display("FAIL reset_rdata: got %h want 00", rdata); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy_rel: got %b want 0", busy); end
    endtask

    task automatic test_basic;
        int base = ren_cnt;
        bit to;
        rec_t e, g;
        send_frame(8'hA5, 1'b1, bit_clks, good_par(8'hA5));
        wait_got(1, to);
        total++;
        if (to) begin
            bad++; $display("FAIL basic_timeout: got %0d strobes want 1", got_q.size());
            exp_q.delete(); got_q.delete();
        end else begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++; if (g.d !== e.d)   begin bad++; $display("FAIL basic_rdata: got %h want %h", g.d, e.d); end
            total++; if (g.fe !== e.fe) begin bad++; $display("FAIL basic_frame_err: got %b want %b", g.fe, e.fe); end
        end
        total++; if (ren_cnt - base != 1) begin bad++; $display("FAIL basic_count: got %0d want 1", ren_cnt - base); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL basic_busy: got %b want 0", busy); end
    endtask

    task automatic test_glitch;
        int base = ren_cnt;
        hold(1'b0, 10);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_hi: got %b want 1", busy); end
        hold(1'b0, 10);
        hold(1'b1, 200);
        total++; if (ren_cnt != base) begin bad++; $display("FAIL glitch_no_ren: got %0d want %0d", ren_cnt, base); end
        total++; if (busy !== 1'b0)   begin bad++; $display("FAIL glitch_busy: got %b want 0", busy); end
        total++; if (rdata !== 8'hA5) begin bad++; $display("FAIL glitch_rdata: got %h want a5", rdata); end
    endtask

    task automatic test_break;
        int base = ren_cnt;
        bit to;
        rec_t e, g;
        send_frame(8'h3C, 1'b0, bit_clks, good_par(8'h3C));
        hold(1'b0, 1000);
        wait_got(1, to);
        total++;
        if (to) begin
            bad++; $display("FAIL break_timeout: got %0d strobes want 1", got_q.size());
            exp_q.delete(); got_q.delete();
        end else begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++; if (g.d !== e.d)   begin bad++; $display("FAIL break_rdata: got %h want %h", g.d, e.d); end
            total++; if (g.fe !== e.fe) begin bad++; $display("FAIL break_frame_err: got %b want %b", g.fe, e.fe); end
        end
        total++; if (ren_cnt - base != 1) begin bad++; $display("FAIL break_count: got %0d want 1", ren_cnt - base); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL break_busy: got %b want 0", busy); end
        hold(1'b1, 100);
        send_frame(8'h12, 1'b1, bit_clks, good_par(8'h12));
        wait_got(1, to);
        total++;
        if (to) begin
            bad++; $display("FAIL break_recover_timeout: got %0d strobes want 1", got_q.size());
            exp_q.delete(); got_q.delete();
        end else begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++; if (g.d !== e.d)   begin bad++; $display("FAIL recover_rdata: got %h want %h", g.d, e.d); end
            total++; if (g.fe !== e.fe) begin bad++; $display("FAIL recover_frame_err: got %b want %b", g.fe, e.fe); end
        end
    endtask

    task automatic test_back_to_back;
        bit to;
        rec_t e, g;
        send_frame(8'h00, 1'b1, bit_clks, good_par(8'h00));
        send_frame(8'hFF, 1'b1, bit_clks, good_par(8'hFF));
        send_frame(8'h5A, 1'b1, 40, good_par(8'h5A));
        send_frame(8'hC3, 1'b1, bit_clks, good_par(8'hC3));
        wait_got(4, to);
        total++;
        if (to) begin
            bad++; $display("FAIL b2b_timeout: got %0d strobes want 4", got_q.size());
            exp_q.delete(); got_q.delete();
        end else begin
            for (int i = 0; i < 4; i++) begin
                e = exp_q.pop_front(); g = got_q.pop_front();
                total++; if (g.d !== e.d)   begin bad++; $display("FAIL b2b_rdata[%0d]: got %h want %h", i, g.d, e.d); end
                total++; if (g.fe !== e.fe) begin bad++; $display("FAIL b2b_frame_err[%0d]: got %b want %b", i, g.fe, e.fe); end
            end
        end
    endtask

    task automatic test_div_latch;
        bit to;
        rec_t e, g;
        fork
            send_frame(8'h96, 1'b1, bit_clks, good_par(8'h96));
            begin
                repeat (200) @(negedge clk);
                baud_div = 16'd0;
            end
        join
        baud_div = 16'd3;
        wait_got(1, to);
        total++;
        if (to) begin
            bad++; $display("FAIL div_latch_timeout: got %0d strobes want 1", got_q.size());
            exp_q.delete(); got_q.delete();
        end else begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++; if (g.d !== e.d) begin bad++; $display("FAIL div_latch_rdata: got %h want %h", g.d, e.d); end
        end
    endtask

    task automatic test_fast_baud;
        bit to;
        rec_t e, g;
        baud_div = 16'd0;
        bit_clks = OS_RATE;
        hold(1'b1, 20);
        send_frame(8'h69, 1'b1, bit_clks, good_par(8'h69));
        send_frame(8'hB4, 1'b0, bit_clks, good_par(8'hB4));
        hold(1'b1, 40);
        wait_got(2, to);
        total++;
        if (to) begin
            bad++; $display("FAIL fast_timeout: got %0d strobes want 2", got_q.size());
            exp_q.delete(); got_q.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                e = exp_q.pop_front(); g = got_q.pop_front();
                total++; if (g.d !== e.d)   begin bad++; $display("FAIL fast_rdata[%0d]: got %h want %h", i, g.d, e.d); end
                total++; if (g.fe !== e.fe) begin bad++; $display("FAIL fast_frame_err[%0d]: got %b want %b", i, g.fe, e.fe); end
            end
        end
        baud_div = 16'd3;
        bit_clks = 64;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        bit to;
        rec_t e, g;
        send_frame(8'h07, 1'b1, bit_clks, 1'b1);
        send_frame(8'h07, 1'b1, bit_clks, 1'b0);
        wait_got(2, to);
        total++;
        if (to) begin
            bad++; $display("FAIL parity_timeout: got %0d strobes want 2", got_q.size());
            exp_q.delete(); got_q.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                e = exp_q.pop_front(); g = got_q.pop_front();
                total++; if (g.d !== e.d)   begin bad++; $display("FAIL parity_rdata[%0d]: got %h want %h", i, g.d, e.d); end
                total++; if (g.pe !== e.pe) begin bad++; $display("FAIL parity_err[%0d]: got %b want %b", i, g.pe, e.pe); end
            end
        end
    endtask
`endif

    task automatic test_reset_mid;
        int base = ren_cnt;
        bit to;
        rec_t e, g;
        hold(1'b0, 64);
        hold(1'b1, 64);
        hold(1'b0, 64);
        hold(1'b1, 30);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_hi: got %b want 1", busy); end
        reset_n = 1'b0;
        hold(1'b1, 5);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        total++; if (rdata !== '0)  begin bad++; $display("FAIL rstmid_rdata: got %h want 00", rdata); end
        reset_n = 1'b1;
        hold(1'b1, 50);
        total++; if (ren_cnt != base) begin bad++; $display("FAIL rstmid_no_ren: got %0d want %0d", ren_cnt, base); end
        send_frame(8'h81, 1'b1, bit_clks, good_par(8'h81));
        wait_got(1, to);
        total++;
        if (to) begin
            bad++; $display("FAIL rstmid_timeout: got %0d strobes want 1", got_q.size());
            exp_q.delete(); got_q.delete();
        end else begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++; if (g.d !== e.d)   begin bad++; $display("FAIL rstmid_rdata_81: got %h want %h", g.d, e.d); end
            total++; if (g.fe !== e.fe) begin bad++; $display("FAIL rstmid_frame_err: got %b want %b", g.fe, e.fe); end
        end
        total++; if (ren_cnt - base != 1) begin bad++; $display("FAIL rstmid_count: got %0d want 1", ren_cnt - base); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_basic;
        test_glitch;
        test_break;
        test_back_to_back;
        test_div_latch;
        test_fast_baud;
`ifdef UART_RX_PARITY_EN
        test_parity;
`endif
        test_reset_mid;
        hold(1'b1, 100);
        total++;
        if (got_q.size() != 0) begin
            bad++; $display("FAIL stray_strobes: got %0d want 0", got_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Parametrised UART receiver, next generation of the single-rate byte receiver in the UART SoC IP. Adds:
- a runtime baud divisor with 16x-style oversampling and mid-bit sampling
- a 2-FF input synchroniser
- configurable data width
- false-start rejection and stop-bit (framing) checking

Each received character is delivered to the receive FIFO as a one-cycle write strobe.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9; LSB received first.
OS_RATE, 16, oversample ticks per bit; even, >= 4.
DIV_W, 16, width of baud_div.
PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
rxd  input  1  serial line; asynchronous; idle high
baud_div  input  DIV_W  oversample tick period minus 1; one tick every baud_div+1 clocks
rdata  output  DATA_BITS  last received character; held until the next ren
ren  output  1  one-cycle strobe: rdata/frame_err/parity_err valid; drives FIFO write
frame_err  output  1  qualified by ren; stop bit sampled 0
parity_err  output  1  qualified by ren; parity mismatch; constant 0 without UART_RX_PARITY_EN
busy  output  1  high in any state other than IDLE

Behaviour:
- Single clock clk. Reset is asynchronous and active-low (reset_n). All flops clear on reset_n low; release is synchronous to clk.
- Reset values: rdata=0, ren=0, frame_err=0, parity_err=0, busy=0, state=IDLE.
- Synchroniser flops and the previous-sample flop reset to 1. Only the synchronised rxd (rxs) is used internally.
- Tick generator: div_cnt counts 0..baud_div, tick when div_cnt==baud_div, then wraps to 0.
  - div_cnt and os_cnt are cleared on leaving IDLE, so the phase aligns to the start edge.
  - baud_div=0 gives a tick every clock.
  - baud_div is sampled only in IDLE; changes mid-frame are ignored until the next frame.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE:
  - Leave only on a falling edge of rxs (previous 1, current 0). A line held low never re-triggers.
  - Go to START; os_cnt=0, bit_cnt=0.
- START:
  - On the tick where os_cnt reaches OS_RATE/2-1 (mid start bit), sample rxs.
  - rxs=1: false start, back to IDLE with no strobe.
  - rxs=0: os_cnt=0, go to DATA.
- DATA:
  - Sample rxs every OS_RATE ticks (mid-bit) into shift position bit_cnt, LSB first.
  - After bit DATA_BITS-1, go to PARITY if compiled in, otherwise STOP.
- STOP:
  - Sample rxs after OS_RATE ticks.
  - Next clock: ren=1 for exactly one cycle; rdata updated; frame_err = ~sample; parity_err per option. Return to IDLE.
  - With a 0 stop bit (break), IDLE waits for the line to go high and then fall again.
- Latency: ren is asserted 1 clock after the stop-bit sample tick. rdata, frame_err and parity_err change only with ren.
- Back-to-back frames: a start edge arriving immediately after the stop-sample point (the half stop bit remaining) is accepted; a minimum of 0.5 bit of stop is tolerated.
- Reset asserted mid-frame: immediate return to IDLE, no ren; the partial character is discarded.
- Widths: os_cnt is clog2(OS_RATE) bits; bit_cnt is clog2(DATA_BITS+1) bits; no truncation of baud_div.

Optional Feature:
UART_RX_PARITY_EN.
- Defined: one parity bit follows the data bits and is sampled in PARITY, mid-bit, OS_RATE ticks after the last data bit. parity_err = (XOR of data bits XOR parity bit) XOR PARITY_ODD, presented with ren.
- Not defined: no PARITY state; frame is start + DATA_BITS + stop; parity_err tied 0.

Test Plan:
1. baud_div=3, OS_RATE=16 (64 clk/bit), send 0xA5 with a good stop bit -> single ren pulse, rdata=0xA5, frame_err=0, busy low after strobe.
2. rxd low glitch for 20 clks (< 32 clk half-bit) -> no ren, busy returns to 0, rdata unchanged.
3. Send 0x3C with stop bit 0, then hold rxd low 1000 clks -> one ren with rdata=0x3C, frame_err=1; no further ren until rxd rises and falls again.
4. Back-to-back 0x00 then 0xFF, second start edge 32 clks after the first stop-sample point -> two ren pulses, rdata 0x00 then 0xFF, frame_err=0 both.
5. With UART_RX_PARITY_EN, PARITY_ODD=0: 0x07 with parity bit 1 -> parity_err=0; same data with parity bit 0 -> parity_err=1.
6. Assert reset_n mid-DATA of 0x55, release, then send 0x81 -> no ren for 0x55; a single ren with rdata=0x81.
